// File: rtl/ex_mem_stage_p.sv
// EX/MEM pipeline register for the branch-predicting MIPS core: latches EX results,
// resolves conditional branches against the fetch prediction and trains the predictor.
module ex_mem_stage_p #(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int NUM_FWD  = 2,
  parameter int CNT_W    = 16,
  parameter int LINK_REG = 31,
  localparam int FS_W    = $clog2(NUM_FWD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    ie_valid,
  input  logic                    ie_mem_write,
  input  logic                    ie_mem_read,
  input  logic                    ie_reg_write,
  input  logic                    ie_mem_to_reg,
  input  logic [1:0]              ie_reg_dst,
  input  logic [1:0]              ie_jump,
  input  logic [2:0]              ie_br_type,
  input  logic                    ie_pred_taken,
  input  logic [XLEN-1:0]         ie_cmp_a,
  input  logic [XLEN-1:0]         ie_cmp_b,
  input  logic [XLEN-1:0]         ie_pc_plus4,
  input  logic [XLEN-1:0]         ie_sign_imm,
  input  logic [XLEN-1:0]         alu_result,
  input  logic [XLEN-1:0]         alu_a,
  input  logic [XLEN-1:0]         ie_reg_data2,
  input  logic [25:0]             ie_jaddr,
  input  logic [RA_W-1:0]         ie_rt,
  input  logic [RA_W-1:0]         ie_rd,
  input  logic [FS_W-1:0]         fw_sel,
  input  logic [NUM_FWD*XLEN-1:0] fw_data,
  output logic                    em_valid,
  output logic                    em_mem_write,
  output logic                    em_mem_read,
  output logic                    em_reg_write,
  output logic                    em_mem_to_reg,
  output logic [1:0]              em_reg_dst,
  output logic [1:0]              em_jump,
  output logic [RA_W-1:0]         em_wb_addr,
  output logic [XLEN-1:0]         em_alu_result,
  output logic [XLEN-1:0]         em_write_data,
  output logic [XLEN-1:0]         em_pc_plus4,
  output logic [XLEN-1:0]         em_alu_a,
  output logic [25:0]             em_jaddr,
  output logic                    em_redirect,
  output logic [XLEN-1:0]         em_redirect_pc,
  output logic                    bp_upd_valid,
  output logic                    bp_upd_taken,
  output logic [XLEN-1:0]         bp_upd_pc,
  output logic [CNT_W-1:0]        br_cnt,
  output logic [CNT_W-1:0]        mispred_cnt
);

  logic            r_valid, r_mem_write, r_mem_read, r_reg_write, r_mem_to_reg;
  logic [1:0]      r_reg_dst, r_jump;
  logic [RA_W-1:0] r_wb_addr;
  logic [XLEN-1:0] r_alu_result, r_write_data, r_pc_plus4, r_alu_a;
  logic [25:0]     r_jaddr;
  logic            r_redirect;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_bp_upd_valid, r_bp_upd_taken;
  logic [XLEN-1:0] r_bp_upd_pc;
  logic [CNT_W-1:0] r_br_cnt, r_mispred_cnt;

  logic            w_cond, w_is_br, w_taken, w_squash, w_live, w_br_ld, w_mis_ld;
  logic            w_a_neg, w_a_zero;
  logic [RA_W-1:0] w_wb_addr;
  logic [XLEN-1:0] w_wdata, w_redirect_pc;

  assign w_a_neg  = ie_cmp_a[XLEN-1];
  assign w_a_zero = (ie_cmp_a == '0);

  always_comb begin
    w_cond = 1'b0;
    case (ie_br_type)
      3'd1:    w_cond = (ie_cmp_a == ie_cmp_b);
      3'd2:    w_cond = (ie_cmp_a != ie_cmp_b);
      3'd3:    w_cond = !w_a_neg && !w_a_zero;
      3'd4:    w_cond = w_a_neg || w_a_zero;
      3'd5:    w_cond = w_a_neg;
      3'd6:    w_cond = !w_a_neg;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_is_br  = (ie_br_type != 3'd0) && (ie_br_type != 3'd7);
  assign w_taken  = ie_valid && w_is_br && w_cond;
  // A resident redirect or jump kills whatever is entering behind it.
  assign w_squash = r_valid && (r_redirect || (r_jump != 2'd0));
  assign w_live   = ie_valid && !w_squash;
  assign w_br_ld  = w_live && w_is_br;
  assign w_mis_ld = w_br_ld && (w_taken != ie_pred_taken);

  assign w_redirect_pc = w_taken ? (ie_pc_plus4 + (ie_sign_imm << 2)) : ie_pc_plus4;

  always_comb begin
    w_wb_addr = '0;
    case (ie_reg_dst)
      2'd0:    w_wb_addr = ie_rt;
      2'd1:    w_wb_addr = ie_rd;
      2'd2:    w_wb_addr = RA_W'(LINK_REG);
      default: w_wb_addr = '0;
    endcase
  end

  always_comb begin
    w_wdata = '0;
    if (fw_sel == '0) w_wdata = ie_reg_data2;
    for (int k = 1; k <= NUM_FWD; k++) begin
      if (fw_sel == FS_W'(k)) w_wdata = fw_data[k*XLEN-1 -: XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_valid        <= 1'b0;
      r_mem_write    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_reg_write    <= 1'b0;
      r_mem_to_reg   <= 1'b0;
      r_reg_dst      <= '0;
      r_jump         <= '0;
      r_wb_addr      <= '0;
      r_alu_result   <= '0;
      r_write_data   <= '0;
      r_pc_plus4     <= '0;
      r_alu_a        <= '0;
      r_jaddr        <= '0;
      r_redirect     <= 1'b0;
      r_redirect_pc  <= '0;
      r_bp_upd_valid <= 1'b0;
      r_bp_upd_taken <= 1'b0;
      r_bp_upd_pc    <= '0;
    end else if (stall_i) begin
      r_bp_upd_valid <= 1'b0;
    end else begin
      r_valid        <= w_live;
      r_mem_write    <= w_live && ie_mem_write;
      r_mem_read     <= w_live && ie_mem_read;
      r_reg_write    <= w_live && ie_reg_write;
      r_mem_to_reg   <= w_live && ie_mem_to_reg;
      r_reg_dst      <= w_live ? ie_reg_dst : 2'd0;
      r_jump         <= w_live ? ie_jump : 2'd0;
      r_wb_addr      <= w_wb_addr;
      r_alu_result   <= alu_result;
      r_write_data   <= w_wdata;
      r_pc_plus4     <= ie_pc_plus4;
      r_alu_a        <= alu_a;
      r_jaddr        <= ie_jaddr;
      r_redirect     <= w_mis_ld;
      r_redirect_pc  <= w_redirect_pc;
      r_bp_upd_valid <= w_br_ld;
      r_bp_upd_taken <= w_taken;
      r_bp_upd_pc    <= ie_pc_plus4;
    end
  end

  // Counters only advance on a genuine load, never on flush or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else if (!flush_i && !stall_i) begin
      if (w_br_ld && !(&r_br_cnt))       r_br_cnt      <= r_br_cnt + CNT_W'(1);
      if (w_mis_ld && !(&r_mispred_cnt)) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end
  end

  assign em_valid       = r_valid;
  assign em_mem_write   = r_mem_write;
  assign em_mem_read    = r_mem_read;
  assign em_reg_write   = r_reg_write;
  assign em_mem_to_reg  = r_mem_to_reg;
  assign em_reg_dst     = r_reg_dst;
  assign em_jump        = r_jump;
  assign em_wb_addr     = r_wb_addr;
  assign em_alu_result  = r_alu_result;
  assign em_write_data  = r_write_data;
  assign em_pc_plus4    = r_pc_plus4;
  assign em_alu_a       = r_alu_a;
  assign em_jaddr       = r_jaddr;
  assign em_redirect    = r_redirect;
  assign em_redirect_pc = r_redirect_pc;
  assign bp_upd_valid   = r_bp_upd_valid;
  assign bp_upd_taken   = r_bp_upd_taken;
  assign bp_upd_pc      = r_bp_upd_pc;
  assign br_cnt         = r_br_cnt;
  assign mispred_cnt    = r_mispred_cnt;

endmodule

// File: tb/tb_ex_mem_stage_p.sv
// Bench for ex_mem_stage_p: directed vector table, reset/stall corner sequences and
// randomized traffic against a behavioural model; a CNT_W=2 copy checks saturation.
module tb_ex_mem_stage_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall_i, flush_i, ie_valid;
  logic        ie_mem_write, ie_mem_read, ie_reg_write, ie_mem_to_reg, ie_pred_taken;
  logic [1:0]  ie_reg_dst, ie_jump, fw_sel;
  logic [2:0]  ie_br_type;
  logic [31:0] ie_cmp_a, ie_cmp_b, ie_pc_plus4, ie_sign_imm, alu_result, alu_a, ie_reg_data2;
  logic [25:0] ie_jaddr;
  logic [4:0]  ie_rt, ie_rd;
  logic [63:0] fw_data;

  logic        em_valid, em_mem_write, em_mem_read, em_reg_write, em_mem_to_reg;
  logic [1:0]  em_reg_dst, em_jump;
  logic [4:0]  em_wb_addr;
  logic [31:0] em_alu_result, em_write_data, em_pc_plus4, em_alu_a, em_redirect_pc, bp_upd_pc;
  logic [25:0] em_jaddr;
  logic        em_redirect, bp_upd_valid, bp_upd_taken;
  logic [15:0] br_cnt, mispred_cnt;

  logic        s_valid, s_mem_write, s_mem_read, s_reg_write, s_mem_to_reg;
  logic [1:0]  s_reg_dst, s_jump;
  logic [4:0]  s_wb_addr;
  logic [31:0] s_alu_result, s_write_data, s_pc_plus4, s_alu_a, s_redirect_pc, s_bp_upd_pc;
  logic [25:0] s_jaddr;
  logic        s_redirect, s_bp_upd_valid, s_bp_upd_taken;
  logic [1:0]  s_br_cnt, s_mispred_cnt;

  ex_mem_stage_p dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .ie_valid(ie_valid),
    .ie_mem_write(ie_mem_write), .ie_mem_read(ie_mem_read), .ie_reg_write(ie_reg_write),
    .ie_mem_to_reg(ie_mem_to_reg), .ie_reg_dst(ie_reg_dst), .ie_jump(ie_jump),
    .ie_br_type(ie_br_type), .ie_pred_taken(ie_pred_taken), .ie_cmp_a(ie_cmp_a),
    .ie_cmp_b(ie_cmp_b), .ie_pc_plus4(ie_pc_plus4), .ie_sign_imm(ie_sign_imm),
    .alu_result(alu_result), .alu_a(alu_a), .ie_reg_data2(ie_reg_data2), .ie_jaddr(ie_jaddr),
    .ie_rt(ie_rt), .ie_rd(ie_rd), .fw_sel(fw_sel), .fw_data(fw_data),
    .em_valid(em_valid), .em_mem_write(em_mem_write), .em_mem_read(em_mem_read),
    .em_reg_write(em_reg_write), .em_mem_to_reg(em_mem_to_reg), .em_reg_dst(em_reg_dst),
    .em_jump(em_jump), .em_wb_addr(em_wb_addr), .em_alu_result(em_alu_result),
    .em_write_data(em_write_data), .em_pc_plus4(em_pc_plus4), .em_alu_a(em_alu_a),
    .em_jaddr(em_jaddr), .em_redirect(em_redirect), .em_redirect_pc(em_redirect_pc),
    .bp_upd_valid(bp_upd_valid), .bp_upd_taken(bp_upd_taken), .bp_upd_pc(bp_upd_pc),
    .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  ex_mem_stage_p #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .ie_valid(ie_valid),
    .ie_mem_write(ie_mem_write), .ie_mem_read(ie_mem_read), .ie_reg_write(ie_reg_write),
    .ie_mem_to_reg(ie_mem_to_reg), .ie_reg_dst(ie_reg_dst), .ie_jump(ie_jump),
    .ie_br_type(ie_br_type), .ie_pred_taken(ie_pred_taken), .ie_cmp_a(ie_cmp_a),
    .ie_cmp_b(ie_cmp_b), .ie_pc_plus4(ie_pc_plus4), .ie_sign_imm(ie_sign_imm),
    .alu_result(alu_result), .alu_a(alu_a), .ie_reg_data2(ie_reg_data2), .ie_jaddr(ie_jaddr),
    .ie_rt(ie_rt), .ie_rd(ie_rd), .fw_sel(fw_sel), .fw_data(fw_data),
    .em_valid(s_valid), .em_mem_write(s_mem_write), .em_mem_read(s_mem_read),
    .em_reg_write(s_reg_write), .em_mem_to_reg(s_mem_to_reg), .em_reg_dst(s_reg_dst),
    .em_jump(s_jump), .em_wb_addr(s_wb_addr), .em_alu_result(s_alu_result),
    .em_write_data(s_write_data), .em_pc_plus4(s_pc_plus4), .em_alu_a(s_alu_a),
    .em_jaddr(s_jaddr), .em_redirect(s_redirect), .em_redirect_pc(s_redirect_pc),
    .bp_upd_valid(s_bp_upd_valid), .bp_upd_taken(s_bp_upd_taken), .bp_upd_pc(s_bp_upd_pc),
    .br_cnt(s_br_cnt), .mispred_cnt(s_mispred_cnt)
  );

  typedef struct packed {
    logic valid, mw, mr, rw, m2r;
    logic [1:0] rdst, jump;
    logic [4:0] wb;
    logic [31:0] alu, wd, pc4, alua;
    logic [25:0] jaddr;
    logic redir;
    logic [31:0] rpc;
    logic bpv, bpt;
    logic [31:0] bpc;
    int brc, misc, sbrc, smisc;
  } m_t;

  typedef struct {
    bit stall, flush, valid, mw;
    bit [1:0] jump;
    bit [2:0] br;
    bit pred;
    bit [31:0] a, b, pc4, imm;
    bit [1:0] fsel;
    bit [31:0] fdat1, rd2;
    bit ev, emw;
    bit [1:0] ej;
    bit er;
    bit [31:0] rpc;
    bit bpv, bpt;
    bit [31:0] wd;
    int brc, mc;
  } vec_t;

  m_t m;
  vec_t tbl[$];
  int n_cmp = 0;
  int n_mis = 0;

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Next architectural state of the stage, computed directly from the behavioural rules.
  function automatic m_t model_next(input m_t c);
    m_t n;
    int sa, sb;
    bit is_br, cond, taken, live;
    n = c;
    if (rst) begin
      n = '0;
      return n;
    end
    if (flush_i) begin
      n = '0;
      n.brc = c.brc; n.misc = c.misc; n.sbrc = c.sbrc; n.smisc = c.smisc;
      return n;
    end
    if (stall_i) begin
      n.bpv = 1'b0;
      return n;
    end
    sa = $signed(ie_cmp_a);
    sb = $signed(ie_cmp_b);
    case (ie_br_type)
      3'd1: cond = (sa == sb);
      3'd2: cond = (sa != sb);
      3'd3: cond = (sa > 0);
      3'd4: cond = (sa <= 0);
      3'd5: cond = (sa < 0);
      3'd6: cond = (sa >= 0);
      default: cond = 1'b0;
    endcase
    is_br = (ie_br_type >= 3'd1) && (ie_br_type <= 3'd6);
    taken = ie_valid && is_br && cond;
    live  = ie_valid && !(c.valid && (c.redir || c.jump != 2'd0));
    n.valid = live;
    n.mw    = live && ie_mem_write;
    n.mr    = live && ie_mem_read;
    n.rw    = live && ie_reg_write;
    n.m2r   = live && ie_mem_to_reg;
    n.rdst  = live ? ie_reg_dst : 2'd0;
    n.jump  = live ? ie_jump : 2'd0;
    case (ie_reg_dst)
      2'd0: n.wb = ie_rt;
      2'd1: n.wb = ie_rd;
      2'd2: n.wb = 5'd31;
      default: n.wb = 5'd0;
    endcase
    n.alu  = alu_result;
    case (fw_sel)
      2'd0: n.wd = ie_reg_data2;
      2'd1: n.wd = fw_data[31:0];
      2'd2: n.wd = fw_data[63:32];
      default: n.wd = 32'd0;
    endcase
    n.pc4   = ie_pc_plus4;
    n.alua  = alu_a;
    n.jaddr = ie_jaddr;
    n.redir = live && is_br && (taken != ie_pred_taken);
    n.rpc   = taken ? ie_pc_plus4 + ie_sign_imm * 4 : ie_pc_plus4;
    n.bpv   = live && is_br;
    n.bpt   = taken;
    n.bpc   = ie_pc_plus4;
    if (n.bpv)   begin n.brc  = sat_inc(c.brc, 65535);  n.sbrc  = sat_inc(c.sbrc, 3);  end
    if (n.redir) begin n.misc = sat_inc(c.misc, 65535); n.smisc = sat_inc(c.smisc, 3); end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("em_valid", 64'(em_valid), 64'(m.valid));
    chk("em_mem_write", 64'(em_mem_write), 64'(m.mw));
    chk("em_mem_read", 64'(em_mem_read), 64'(m.mr));
    chk("em_reg_write", 64'(em_reg_write), 64'(m.rw));
    chk("em_mem_to_reg", 64'(em_mem_to_reg), 64'(m.m2r));
    chk("em_reg_dst", 64'(em_reg_dst), 64'(m.rdst));
    chk("em_jump", 64'(em_jump), 64'(m.jump));
    chk("em_wb_addr", 64'(em_wb_addr), 64'(m.wb));
    chk("em_alu_result", 64'(em_alu_result), 64'(m.alu));
    chk("em_write_data", 64'(em_write_data), 64'(m.wd));
    chk("em_pc_plus4", 64'(em_pc_plus4), 64'(m.pc4));
    chk("em_alu_a", 64'(em_alu_a), 64'(m.alua));
    chk("em_jaddr", 64'(em_jaddr), 64'(m.jaddr));
    chk("em_redirect", 64'(em_redirect), 64'(m.redir));
    chk("em_redirect_pc", 64'(em_redirect_pc), 64'(m.rpc));
    chk("bp_upd_valid", 64'(bp_upd_valid), 64'(m.bpv));
    chk("bp_upd_taken", 64'(bp_upd_taken), 64'(m.bpt));
    chk("bp_upd_pc", 64'(bp_upd_pc), 64'(m.bpc));
    chk("br_cnt", 64'(br_cnt), 64'(m.brc));
    chk("mispred_cnt", 64'(mispred_cnt), 64'(m.misc));
    chk("sat_br_cnt", 64'(s_br_cnt), 64'(m.sbrc));
    chk("sat_mispred_cnt", 64'(s_mispred_cnt), 64'(m.smisc));
  endtask

  task automatic cyc();
    m_t nx;
    nx = model_next(m);
    @(posedge clk);
    #1;
    m = nx;
    check_all();
  endtask

  task automatic rand_inputs();
    logic [31:0] pool [6];
    pool = '{32'd0, 32'd1, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, $urandom};
    stall_i       = ($urandom_range(0, 5) == 0);
    flush_i       = ($urandom_range(0, 15) == 0);
    ie_valid      = ($urandom_range(0, 4) != 0);
    ie_mem_write  = 1'($urandom);
    ie_mem_read   = 1'($urandom);
    ie_reg_write  = 1'($urandom);
    ie_mem_to_reg = 1'($urandom);
    ie_reg_dst    = 2'($urandom);
    ie_jump       = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    ie_br_type    = 3'($urandom);
    ie_pred_taken = 1'($urandom);
    ie_cmp_a      = pool[$urandom_range(0, 5)];
    ie_cmp_b      = pool[$urandom_range(0, 5)];
    ie_pc_plus4   = $urandom;
    ie_sign_imm   = $urandom;
    alu_result    = $urandom;
    alu_a         = $urandom;
    ie_reg_data2  = $urandom;
    ie_jaddr      = 26'($urandom);
    ie_rt         = 5'($urandom);
    ie_rd         = 5'($urandom);
    fw_sel        = 2'($urandom);
    fw_data       = {$urandom, $urandom};
  endtask

  function automatic vec_t mk(input bit st, fl, v, mw, input bit [1:0] j, input bit [2:0] br,
                              input bit pr, input bit [31:0] a, b, pc4, imm, input bit [1:0] fs,
                              input bit [31:0] fd1, rd2, input bit ev, emw, input bit [1:0] ej,
                              input bit er, input bit [31:0] rpc, input bit bpv, bpt,
                              input bit [31:0] wd, input int brc, mc);
    vec_t t;
    t.stall = st; t.flush = fl; t.valid = v; t.mw = mw; t.jump = j; t.br = br; t.pred = pr;
    t.a = a; t.b = b; t.pc4 = pc4; t.imm = imm; t.fsel = fs; t.fdat1 = fd1; t.rd2 = rd2;
    t.ev = ev; t.emw = emw; t.ej = ej; t.er = er; t.rpc = rpc; t.bpv = bpv; t.bpt = bpt;
    t.wd = wd; t.brc = brc; t.mc = mc;
    return t;
  endfunction

  initial begin
    // stall flush v mw j br pr a b pc4 imm fsel fdat1 rd2 | ev emw ej er rpc bpv bpt wd brc mc
    tbl.push_back(mk(0,0,1,0,0,1,0, 5, 5, 'h100, 4, 0, 0, 'hA0, 1,0,0,1, 'h110, 1,1, 'hA0, 1,1));
    tbl.push_back(mk(0,0,1,1,0,0,0, 0, 0, 'h104, 0, 0, 0, 'hA1, 0,0,0,0, 'h104, 0,0, 'hA1, 1,1));
    tbl.push_back(mk(0,0,1,1,0,0,0, 0, 0, 'h108, 0, 0, 0, 'hA2, 1,1,0,0, 'h108, 0,0, 'hA2, 1,1));
    tbl.push_back(mk(0,0,1,0,0,3,0, 'h80000000, 0, 'h200, 8, 0, 0, 'hA3, 1,0,0,0, 'h200, 1,0, 'hA3, 2,1));
    tbl.push_back(mk(0,0,1,0,0,2,0, 1, 2, 'h300, 'hFFFFFFFF, 0, 0, 'hA4, 1,0,0,1, 'h2FC, 1,1, 'hA4, 3,2));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,1,0,0,1,0, 5, 5, 'h400, 0, 0, 0, 'hA5, 1,0,0,1, 'h2FC, 0,1, 'hA4, 3,2));
    tbl.push_back(mk(1,1,1,1,0,0,0, 0, 0, 'h500, 0, 0, 0, 'hA8, 0,0,0,0, 0, 0,0, 0, 3,2));
    tbl.push_back(mk(0,0,1,0,0,4,1, 0, 0, 'h600, 2, 0, 0, 'hA9, 1,0,0,0, 'h608, 1,1, 'hA9, 4,2));
    tbl.push_back(mk(0,0,1,0,0,5,0, 'hFFFFFFFF, 0, 'h700, 1, 0, 0, 'hAA, 1,0,0,1, 'h704, 1,1, 'hAA, 5,3));
    tbl.push_back(mk(0,0,1,0,0,6,1, 'hFFFFFFFF, 0, 'h800, 1, 0, 0, 'hAB, 0,0,0,0, 'h800, 0,0, 'hAB, 5,3));
    tbl.push_back(mk(0,0,1,0,0,6,1, 'hFFFFFFFF, 0, 'h900, 1, 0, 0, 'hAC, 1,0,0,1, 'h900, 1,0, 'hAC, 6,4));
    tbl.push_back(mk(0,0,1,0,0,7,0, 3, 3, 'hA00, 1, 0, 0, 'hAD, 0,0,0,0, 'hA00, 0,0, 'hAD, 6,4));
    tbl.push_back(mk(0,0,1,0,0,7,1, 3, 3, 'hB00, 1, 0, 0, 'hAE, 1,0,0,0, 'hB00, 0,0, 'hAE, 6,4));
    tbl.push_back(mk(0,0,1,0,2,0,0, 0, 0, 'hC00, 0, 0, 0, 'hAF, 1,0,2,0, 'hC00, 0,0, 'hAF, 6,4));
    tbl.push_back(mk(0,0,1,1,0,0,0, 0, 0, 'hD00, 0, 2, 'hDEAD, 'hB0, 0,0,0,0, 'hD00, 0,0, 'hDEAD, 6,4));
    tbl.push_back(mk(0,0,1,1,0,0,0, 0, 0, 'hE00, 0, 2, 'hDEAD, 'hB1, 1,1,0,0, 'hE00, 0,0, 'hDEAD, 6,4));
    tbl.push_back(mk(0,0,1,1,0,0,0, 0, 0, 'hF00, 0, 3, 'hDEAD, 'hB2, 1,1,0,0, 'hF00, 0,0, 0, 6,4));
    tbl.push_back(mk(0,0,0,1,0,1,0, 4, 4, 'h1000, 3, 0, 0, 'hB3, 0,0,0,0, 'h1000, 0,0, 'hB3, 6,4));
    tbl.push_back(mk(0,0,1,0,0,5,0, 'hFFFFFFFB, 0, 'h1100, 0, 0, 0, 'hB4, 1,0,0,1, 'h1100, 1,1, 'hB4, 7,5));

    m = '0;
    rand_inputs();
    rst = 1'b1;
    cyc();
    rand_inputs();
    cyc();
    chk("reset em_valid", 64'(em_valid), 64'd0);
    chk("reset em_redirect_pc", 64'(em_redirect_pc), 64'd0);
    chk("reset br_cnt", 64'(br_cnt), 64'd0);
    chk("reset mispred_cnt", 64'(mispred_cnt), 64'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      stall_i = tbl[i].stall; flush_i = tbl[i].flush; ie_valid = tbl[i].valid;
      ie_mem_write = tbl[i].mw; ie_mem_read = 1'b0; ie_reg_write = tbl[i].valid;
      ie_mem_to_reg = 1'b0; ie_reg_dst = 2'd1; ie_jump = tbl[i].jump;
      ie_br_type = tbl[i].br; ie_pred_taken = tbl[i].pred;
      ie_cmp_a = tbl[i].a; ie_cmp_b = tbl[i].b; ie_pc_plus4 = tbl[i].pc4;
      ie_sign_imm = tbl[i].imm; alu_result = tbl[i].pc4 + 32'd100; alu_a = tbl[i].pc4 + 32'd200;
      ie_reg_data2 = tbl[i].rd2; ie_jaddr = tbl[i].pc4[25:0]; ie_rt = 5'd3; ie_rd = 5'd9;
      fw_sel = tbl[i].fsel; fw_data = {tbl[i].fdat1, 32'h1234_5678};
      cyc();
      chk($sformatf("vec%0d em_valid", i), 64'(em_valid), 64'(tbl[i].ev));
      chk($sformatf("vec%0d em_mem_write", i), 64'(em_mem_write), 64'(tbl[i].emw));
      chk($sformatf("vec%0d em_jump", i), 64'(em_jump), 64'(tbl[i].ej));
      chk($sformatf("vec%0d em_redirect", i), 64'(em_redirect), 64'(tbl[i].er));
      chk($sformatf("vec%0d em_redirect_pc", i), 64'(em_redirect_pc), 64'(tbl[i].rpc));
      chk($sformatf("vec%0d bp_upd_valid", i), 64'(bp_upd_valid), 64'(tbl[i].bpv));
      chk($sformatf("vec%0d bp_upd_taken", i), 64'(bp_upd_taken), 64'(tbl[i].bpt));
      chk($sformatf("vec%0d em_write_data", i), 64'(em_write_data), 64'(tbl[i].wd));
      chk($sformatf("vec%0d br_cnt", i), 64'(br_cnt), 64'(tbl[i].brc));
      chk($sformatf("vec%0d mispred_cnt", i), 64'(mispred_cnt), 64'(tbl[i].mc));
    end
    chk("sat mispred_cnt after 5 mispredicts", 64'(s_mispred_cnt), 64'd3);
    chk("sat br_cnt after 7 branches", 64'(s_br_cnt), 64'd3);

    for (int c = 0; c < 800; c++) begin
      rand_inputs();
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;

    // reset arriving while the stage is held must still clear everything
    rand_inputs();
    stall_i = 1'b1; flush_i = 1'b0;
    cyc();
    rand_inputs();
    stall_i = 1'b1; flush_i = 1'b0; rst = 1'b1;
    cyc();
    chk("reset-in-stall em_valid", 64'(em_valid), 64'd0);
    chk("reset-in-stall em_redirect", 64'(em_redirect), 64'd0);
    chk("reset-in-stall br_cnt", 64'(br_cnt), 64'd0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
